// File: rtl/cafeteira_uc.sv
// cafeteira_uc -- control unit (Moore FSM) of the coffee maker.
// Waits for an order on the serial link, checks the water level and the cup,
// then runs pump -> boiler -> valve and reports done or an error code.
// Optional feature: define CAFETEIRA_UC_XICARA_RETRY_EN to re-arm the cup
// sensor up to N_TENTATIVAS-1 times before declaring "no cup".
module cafeteira_uc #(
  parameter int N_TENTATIVAS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       limpa_erro,
  // datapath status
  input  logic       pronto_serial,
  input  logic       pronto_sensor_agua,
  input  logic       suficiente,
  input  logic       timeout_agua,
  input  logic       pronto_sensor_xicara,
  input  logic       tem_xicara,
  input  logic       timeout_xicara,
  input  logic       fim_bomba,
  input  logic       timeout_ebulidor,
  input  logic       fim_valvula,
  // datapath clears
  output logic       zera_serial,
  output logic       zera_sensor_agua,
  output logic       zera_timeout_agua,
  output logic       zera_sensor_xicara,
  output logic       zera_timeout_xicara,
  output logic       zera_bomba,
  output logic       zera_valvula,
  output logic       zera_timeout_ebulidor,
  // datapath strobes / counter enables
  output logic       medir_agua,
  output logic       conta_timeout_agua,
  output logic       verifica_xicara,
  output logic       conta_timeout_xicara,
  output logic       conta_bomba,
  output logic       conta_timeout_ebulidor,
  output logic       conta_valvula,
  // actuator enables
  output logic       liga_bomba,
  output logic       liga_ebulidor,
  output logic       abre_valvula,
  // status
  output logic       pronto,
  output logic       erro,
  output logic [1:0] erro_codigo,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL         = 4'h0,
    ESPERA_PEDIDO   = 4'h1,
    PREPARA         = 4'h2,
    MEDE_AGUA       = 4'h3,
    ESPERA_AGUA     = 4'h4,
    VERIFICA_XICARA = 4'h5,
    ESPERA_XICARA   = 4'h6,
    REARMA_XICARA   = 4'h7,
    BOMBEIA         = 4'h8,
    AQUECE          = 4'h9,
    SERVE           = 4'hA,
    FIM             = 4'hB,
    ERRO            = 4'hF
  } estado_t;

  localparam logic [1:0] COD_NENHUM      = 2'b00;
  localparam logic [1:0] COD_AGUA_BAIXA  = 2'b01;
  localparam logic [1:0] COD_AGUA_TMO    = 2'b10;
  localparam logic [1:0] COD_SEM_XICARA  = 2'b11;

  // Last attempt index that may still re-arm the cup sensor.
  localparam logic [3:0] LIMITE_TENTATIVAS = 4'(N_TENTATIVAS - 1);

  estado_t    estado, prox_estado;
  logic [1:0] codigo_q, codigo_d;
  logic       xicara_ok, xicara_falha, pode_rearmar;

  // Cup sensor result: a valid reading wins over a simultaneous timeout.
  assign xicara_ok    = pronto_sensor_xicara & tem_xicara;
  assign xicara_falha = (pronto_sensor_xicara & ~tem_xicara) | (timeout_xicara & ~pronto_sensor_xicara);

`ifdef CAFETEIRA_UC_XICARA_RETRY_EN
  logic [3:0] tentativas_q;

  // Attempt counter: cleared per order, +1 per re-arm, saturating at 15.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tentativas_q <= '0;
    end else if (estado == PREPARA) begin
      tentativas_q <= '0;
    end else if (estado == REARMA_XICARA && tentativas_q != 4'hF) begin
      tentativas_q <= tentativas_q + 4'd1;
    end
  end

  assign pode_rearmar = (tentativas_q < LIMITE_TENTATIVAS);
`else
  // Without retries the attempt limit has no effect.
  logic unused_cfg;
  assign unused_cfg   = ^LIMITE_TENTATIVAS;
  assign pode_rearmar = 1'b0;
`endif

  // State register and error-code register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado   <= INICIAL;
      codigo_q <= COD_NENHUM;
    end else begin
      estado   <= prox_estado;
      codigo_q <= codigo_d;
    end
  end

  // Next-state logic; also chooses the error code loaded when entering ERRO.
  // NOTE: every variable gets a default at the top of the always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    prox_estado = estado;
    codigo_d    = COD_NENHUM;
    case (estado)
      INICIAL:       prox_estado = ESPERA_PEDIDO;
      ESPERA_PEDIDO: if (pronto_serial) prox_estado = PREPARA;
      PREPARA:       prox_estado = MEDE_AGUA;
      MEDE_AGUA:     prox_estado = ESPERA_AGUA;
      ESPERA_AGUA: begin
        if (pronto_sensor_agua) begin
          if (suficiente) begin
            prox_estado = VERIFICA_XICARA;
          end else begin
            prox_estado = ERRO;
            codigo_d    = COD_AGUA_BAIXA;
          end
        end else if (timeout_agua) begin
          prox_estado = ERRO;
          codigo_d    = COD_AGUA_TMO;
        end
      end
      VERIFICA_XICARA: prox_estado = ESPERA_XICARA;
      ESPERA_XICARA: begin
        if (xicara_ok) begin
          prox_estado = BOMBEIA;
        end else if (xicara_falha) begin
          if (pode_rearmar) begin
            prox_estado = REARMA_XICARA;
          end else begin
            prox_estado = ERRO;
            codigo_d    = COD_SEM_XICARA;
          end
        end
      end
      REARMA_XICARA: prox_estado = VERIFICA_XICARA;
      BOMBEIA:       if (fim_bomba) prox_estado = AQUECE;
      AQUECE:        if (timeout_ebulidor) prox_estado = SERVE;
      SERVE:         if (fim_valvula) prox_estado = FIM;
      FIM:           prox_estado = INICIAL;
      ERRO: begin
        if (limpa_erro) begin
          prox_estado = INICIAL;
        end else begin
          codigo_d = codigo_q;
        end
      end
      default:       prox_estado = INICIAL;
    endcase
  end

  // Moore output decode from the registered state only.
  always_comb begin
    zera_serial            = 1'b0;
    zera_sensor_agua       = 1'b0;
    zera_timeout_agua      = 1'b0;
    zera_sensor_xicara     = 1'b0;
    zera_timeout_xicara    = 1'b0;
    zera_bomba             = 1'b0;
    zera_valvula           = 1'b0;
    zera_timeout_ebulidor  = 1'b0;
    medir_agua             = 1'b0;
    conta_timeout_agua     = 1'b0;
    verifica_xicara        = 1'b0;
    conta_timeout_xicara   = 1'b0;
    conta_bomba            = 1'b0;
    conta_timeout_ebulidor = 1'b0;
    conta_valvula          = 1'b0;
    liga_bomba             = 1'b0;
    liga_ebulidor          = 1'b0;
    abre_valvula           = 1'b0;
    pronto                 = 1'b0;
    erro                   = 1'b0;
    case (estado)
      INICIAL: zera_serial = 1'b1;
      PREPARA: begin
        zera_sensor_agua      = 1'b1;
        zera_timeout_agua     = 1'b1;
        zera_sensor_xicara    = 1'b1;
        zera_timeout_xicara   = 1'b1;
        zera_bomba            = 1'b1;
        zera_valvula          = 1'b1;
        zera_timeout_ebulidor = 1'b1;
      end
      MEDE_AGUA: begin
        medir_agua         = 1'b1;
        conta_timeout_agua = 1'b1;
      end
      ESPERA_AGUA: conta_timeout_agua = 1'b1;
      VERIFICA_XICARA: begin
        verifica_xicara      = 1'b1;
        conta_timeout_xicara = 1'b1;
      end
      ESPERA_XICARA: conta_timeout_xicara = 1'b1;
      REARMA_XICARA: begin
        zera_timeout_xicara = 1'b1;
        zera_sensor_xicara  = 1'b1;
      end
      BOMBEIA: begin
        liga_bomba  = 1'b1;
        conta_bomba = 1'b1;
      end
      AQUECE: begin
        liga_ebulidor          = 1'b1;
        conta_timeout_ebulidor = 1'b1;
      end
      SERVE: begin
        abre_valvula  = 1'b1;
        conta_valvula = 1'b1;
      end
      FIM:  pronto = 1'b1;
      ERRO: erro   = 1'b1;
      default: ;
    endcase
  end

  // The code register is only non-zero while in ERRO.
  assign erro_codigo = codigo_q;
  assign db_estado   = estado;

endmodule

// File: tb/tb_cafeteira_uc.sv
// Directed bench for cafeteira_uc: nominal order, low water, water timeout,
// pronto/timeout collision, cup failure (with or without retries) and an
// asynchronous reset while heating. Expected states go through a queue.
module tb_cafeteira_uc;

  logic       clock = 1'b0;
  logic       reset;
  logic       limpa_erro;
  logic       pronto_serial, pronto_sensor_agua, suficiente, timeout_agua;
  logic       pronto_sensor_xicara, tem_xicara, timeout_xicara;
  logic       fim_bomba, timeout_ebulidor, fim_valvula;
  logic       zera_serial, zera_sensor_agua, zera_timeout_agua, zera_sensor_xicara;
  logic       zera_timeout_xicara, zera_bomba, zera_valvula, zera_timeout_ebulidor;
  logic       medir_agua, conta_timeout_agua, verifica_xicara, conta_timeout_xicara;
  logic       conta_bomba, conta_timeout_ebulidor, conta_valvula;
  logic       liga_bomba, liga_ebulidor, abre_valvula;
  logic       pronto, erro;
  logic [1:0] erro_codigo;
  logic [3:0] db_estado;

  cafeteira_uc #(.N_TENTATIVAS(3)) dut (
    .clock(clock), .reset(reset), .limpa_erro(limpa_erro),
    .pronto_serial(pronto_serial), .pronto_sensor_agua(pronto_sensor_agua),
    .suficiente(suficiente), .timeout_agua(timeout_agua),
    .pronto_sensor_xicara(pronto_sensor_xicara), .tem_xicara(tem_xicara),
    .timeout_xicara(timeout_xicara), .fim_bomba(fim_bomba),
    .timeout_ebulidor(timeout_ebulidor), .fim_valvula(fim_valvula),
    .zera_serial(zera_serial), .zera_sensor_agua(zera_sensor_agua),
    .zera_timeout_agua(zera_timeout_agua), .zera_sensor_xicara(zera_sensor_xicara),
    .zera_timeout_xicara(zera_timeout_xicara), .zera_bomba(zera_bomba),
    .zera_valvula(zera_valvula), .zera_timeout_ebulidor(zera_timeout_ebulidor),
    .medir_agua(medir_agua), .conta_timeout_agua(conta_timeout_agua),
    .verifica_xicara(verifica_xicara), .conta_timeout_xicara(conta_timeout_xicara),
    .conta_bomba(conta_bomba), .conta_timeout_ebulidor(conta_timeout_ebulidor),
    .conta_valvula(conta_valvula), .liga_bomba(liga_bomba),
    .liga_ebulidor(liga_ebulidor), .abre_valvula(abre_valvula),
    .pronto(pronto), .erro(erro), .erro_codigo(erro_codigo), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      tag;
    logic [3:0] estado;
  } esperado_t;

  esperado_t  sb[$];
  int         n_assert = 0;
  int         n_fail   = 0;
  logic [2:0] act_seen;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance to the falling edge, then check actuator exclusivity.
  task automatic cyc();
    logic [2:0] act;
    @(negedge clock);
    act = {liga_bomba, liga_ebulidor, abre_valvula};
    act_seen = act_seen | act;
    chk("actuator_exclusive", 8'($onehot0(act)), 8'd1);
  endtask

  // Push the state expected after this clock, clock, then pop and compare.
  task automatic step(input string tag, input logic [3:0] exp_estado);
    esperado_t e;
    sb.push_back('{tag, exp_estado});
    cyc();
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 8'd0, 8'd1);
    end else begin
      e = sb.pop_front();
      chk(e.tag, 8'(db_estado), 8'(e.estado));
    end
  endtask

  // From ESPERA_PEDIDO to ESPERA_AGUA.
  task automatic pedido();
    pronto_serial = 1'b1;
    step("pedido_prepara", 4'h2);
    pronto_serial = 1'b0;
    step("pedido_mede", 4'h3);
    step("pedido_espera_agua", 4'h4);
  endtask

  // Acknowledge the error and return to ESPERA_PEDIDO.
  task automatic limpa();
    limpa_erro = 1'b1;
    step("limpa_inicial", 4'h0);
    chk("limpa_codigo", 8'(erro_codigo), 8'h0);
    chk("limpa_erro_low", 8'(erro), 8'h0);
    limpa_erro = 1'b0;
    step("limpa_espera", 4'h1);
  endtask

  initial begin
    reset = 1'b1; limpa_erro = 1'b0;
    pronto_serial = 1'b0; pronto_sensor_agua = 1'b0; suficiente = 1'b0; timeout_agua = 1'b0;
    pronto_sensor_xicara = 1'b0; tem_xicara = 1'b0; timeout_xicara = 1'b0;
    fim_bomba = 1'b0; timeout_ebulidor = 1'b0; fim_valvula = 1'b0;
    act_seen = 3'b000;

    // Reset state
    cyc();
    chk("rst_estado", 8'(db_estado), 8'h0);
    chk("rst_zera_serial", 8'(zera_serial), 8'h1);
    chk("rst_codigo", 8'(erro_codigo), 8'h0);
    chk("rst_pronto_erro", 8'({pronto, erro}), 8'h0);
    reset = 1'b0;
    step("inicial_espera", 4'h1);

    // 1: nominal order
    pronto_serial = 1'b1;
    step("nom_prepara", 4'h2);
    chk("nom_zeras", 8'({zera_sensor_agua, zera_timeout_agua, zera_sensor_xicara,
        zera_timeout_xicara, zera_bomba, zera_valvula, zera_timeout_ebulidor}), 8'h7F);
    chk("nom_zera_serial", 8'(zera_serial), 8'h0);
    pronto_serial = 1'b0;
    step("nom_mede", 4'h3);
    chk("nom_medir", 8'({medir_agua, conta_timeout_agua}), 8'h3);
    step("nom_espera_agua", 4'h4);
    chk("nom_espera_strobes", 8'({medir_agua, conta_timeout_agua}), 8'h1);
    pronto_sensor_agua = 1'b1; suficiente = 1'b1;
    step("nom_verifica", 4'h5);
    chk("nom_verifica_strobes", 8'({verifica_xicara, conta_timeout_xicara}), 8'h3);
    pronto_sensor_agua = 1'b0;
    step("nom_espera_xic", 4'h6);
    pronto_sensor_xicara = 1'b1; tem_xicara = 1'b1;
    step("nom_bombeia", 4'h8);
    chk("nom_bomba_on", 8'({liga_bomba, conta_bomba}), 8'h3);
    pronto_sensor_xicara = 1'b0; tem_xicara = 1'b0;
    repeat (19) cyc();
    chk("nom_bomba_hold", 8'(db_estado), 8'h8);
    fim_bomba = 1'b1;
    step("nom_aquece", 4'h9);
    chk("nom_aquece_act", 8'({liga_bomba, liga_ebulidor, abre_valvula}), 8'h2);
    fim_bomba = 1'b0;
    repeat (49) cyc();
    timeout_ebulidor = 1'b1;
    step("nom_serve", 4'hA);
    chk("nom_serve_act", 8'({liga_bomba, liga_ebulidor, abre_valvula}), 8'h1);
    timeout_ebulidor = 1'b0;
    repeat (9) cyc();
    fim_valvula = 1'b1;
    step("nom_fim", 4'hB);
    chk("nom_pronto_pulse", 8'(pronto), 8'h1);
    fim_valvula = 1'b0;
    step("nom_inicial", 4'h0);
    chk("nom_pronto_end", 8'(pronto), 8'h0);
    step("nom_espera_pedido", 4'h1);

    // 2: low water
    act_seen = 3'b000;
    pedido();
    pronto_sensor_agua = 1'b1; suficiente = 1'b0;
    step("baixa_erro", 4'hF);
    chk("baixa_erro_flag", 8'(erro), 8'h1);
    chk("baixa_codigo", 8'(erro_codigo), 8'h1);
    pronto_sensor_agua = 1'b0;
    step("baixa_hold", 4'hF);
    chk("baixa_codigo_hold", 8'(erro_codigo), 8'h1);
    limpa();
    chk("baixa_no_actuator", 8'(act_seen), 8'h0);
    limpa_erro = 1'b1;
    step("limpa_fora_erro", 4'h1);
    limpa_erro = 1'b0;

    // 3a: water sensor timeout
    pedido();
    step("tmo_espera", 4'h4);
    timeout_agua = 1'b1;
    step("tmo_erro", 4'hF);
    chk("tmo_codigo", 8'(erro_codigo), 8'h2);
    timeout_agua = 1'b0;
    limpa();

    // 3b: pronto and timeout together, pronto wins
    pedido();
    pronto_sensor_agua = 1'b1; suficiente = 1'b1; timeout_agua = 1'b1;
    step("colisao_verifica", 4'h5);
    pronto_sensor_agua = 1'b0; timeout_agua = 1'b0;
    step("colisao_espera_xic", 4'h6);

    // 4: cup failure
`ifdef CAFETEIRA_UC_XICARA_RETRY_EN
    pronto_sensor_xicara = 1'b1; tem_xicara = 1'b0;
    step("retry_rearma1", 4'h7);
    chk("retry_zeras", 8'({zera_timeout_xicara, zera_sensor_xicara}), 8'h3);
    pronto_sensor_xicara = 1'b0;
    step("retry_verifica1", 4'h5);
    step("retry_espera1", 4'h6);
    timeout_xicara = 1'b1;
    step("retry_rearma2", 4'h7);
    timeout_xicara = 1'b0;
    step("retry_verifica2", 4'h5);
    step("retry_espera2", 4'h6);
    pronto_sensor_xicara = 1'b1;
    step("retry_erro", 4'hF);
    chk("retry_codigo", 8'(erro_codigo), 8'h3);
    pronto_sensor_xicara = 1'b0;
    limpa();
    // Counter restarts per order: second check succeeds
    pedido();
    pronto_sensor_agua = 1'b1; suficiente = 1'b1;
    step("retry_ok_verifica", 4'h5);
    pronto_sensor_agua = 1'b0;
    step("retry_ok_espera", 4'h6);
    pronto_sensor_xicara = 1'b1; tem_xicara = 1'b0;
    step("retry_ok_rearma", 4'h7);
    pronto_sensor_xicara = 1'b0;
    step("retry_ok_verifica2", 4'h5);
    step("retry_ok_espera2", 4'h6);
    pronto_sensor_xicara = 1'b1; tem_xicara = 1'b1;
    step("retry_ok_bombeia", 4'h8);
`else
    pronto_sensor_xicara = 1'b1; tem_xicara = 1'b0;
    step("xic_erro", 4'hF);
    chk("xic_codigo", 8'(erro_codigo), 8'h3);
    pronto_sensor_xicara = 1'b0;
    limpa();
    pedido();
    pronto_sensor_agua = 1'b1; suficiente = 1'b1;
    step("xic_ok_verifica", 4'h5);
    pronto_sensor_agua = 1'b0;
    step("xic_ok_espera", 4'h6);
    pronto_sensor_xicara = 1'b1; tem_xicara = 1'b1;
    step("xic_ok_bombeia", 4'h8);
`endif
    pronto_sensor_xicara = 1'b0; tem_xicara = 1'b0;

    // 5: asynchronous reset while heating
    fim_bomba = 1'b1;
    step("async_aquece", 4'h9);
    fim_bomba = 1'b0;
    chk("async_ebulidor_on", 8'(liga_ebulidor), 8'h1);
    #2 reset = 1'b1;
    #1;
    chk("async_ebulidor_off", 8'(liga_ebulidor), 8'h0);
    chk("async_estado", 8'(db_estado), 8'h0);
    chk("async_no_pulse", 8'({pronto, erro}), 8'h0);
    cyc();
    chk("async_hold_estado", 8'(db_estado), 8'h0);
    chk("async_codigo", 8'(erro_codigo), 8'h0);
    reset = 1'b0;
    step("async_release", 4'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
